// File: rtl/rf2d_row_feeder.sv
// Packs a serial pixel stream into NUM_COL-wide rows for the 2-D window register file, loads them
// with rowShift and, once NUM_ROW rows are resident, scans row 0 out with NUM_COL colShift pulses.
module rf2d_row_feeder #(
  parameter int unsigned NUM_COL  = 18,
  parameter int unsigned NUM_ROW  = 16,
  parameter int unsigned NUM_BITS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [NUM_BITS-1:0]          pix_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic [NUM_COL*NUM_BITS-1:0]  data,
  output logic                         rowShift,
  output logic                         colShift,
  output logic                         rf_reset,
  output logic                         primed,
  output logic                         scan_valid,
  output logic [$clog2(NUM_COL)-1:0]   scan_col
);

  localparam int unsigned ColW = $clog2(NUM_COL);
  localparam int unsigned RowW = $clog2(NUM_ROW + 1);
  localparam logic [ColW-1:0] LastCol  = ColW'(NUM_COL - 1);
  localparam logic [RowW-1:0] FullRows = RowW'(NUM_ROW);

  typedef enum logic [1:0] {StFill, StLoad, StScan} state_e;

  state_e                      state;
  logic [NUM_COL*NUM_BITS-1:0] asm_buf;
  logic [NUM_COL*NUM_BITS-1:0] asm_next;
  logic [ColW-1:0]             col_cnt;
  logic [ColW-1:0]             scan_cnt;
  logic [RowW-1:0]             rows_loaded;
  logic                        row_full;
  logic                        accept;
  logic                        last_acc;
  logic                        load_next;

  always_comb begin
    pix_ready = reset & ~row_full & (state != StLoad) & ~frame_start;
    accept    = pix_valid & pix_ready;
    last_acc  = accept & (col_cnt == LastCol);
    asm_next  = asm_buf;
    if (accept) asm_next[32'(col_cnt) * NUM_BITS +: NUM_BITS] = pix_in;
    // A row completing this very cycle goes straight to LOAD, so data comes from asm_next.
    load_next = row_full | last_acc;
  end

  assign primed     = (rows_loaded == FullRows);
  assign scan_valid = colShift;
  assign scan_col   = scan_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StFill;
      asm_buf     <= '0;
      data        <= '0;
      col_cnt     <= '0;
      scan_cnt    <= '0;
      rows_loaded <= '0;
      row_full    <= 1'b0;
      rowShift    <= 1'b0;
      colShift    <= 1'b0;
      rf_reset    <= 1'b0;
    end else if (frame_start) begin
      state       <= StFill;
      col_cnt     <= '0;
      scan_cnt    <= '0;
      rows_loaded <= '0;
      row_full    <= 1'b0;
      rowShift    <= 1'b0;
      colShift    <= 1'b0;
      rf_reset    <= 1'b1;
    end else begin
      rf_reset <= 1'b0;
      asm_buf  <= asm_next;
      if (accept) begin
        col_cnt <= last_acc ? '0 : col_cnt + 1'b1;
        if (last_acc) row_full <= 1'b1;
      end
      case (state)
        StFill: begin
          if (load_next) begin
            state    <= StLoad;
            data     <= asm_next;
            rowShift <= 1'b1;
          end
        end
        StLoad: begin
          rowShift <= 1'b0;
          row_full <= 1'b0;
          if (rows_loaded != FullRows) rows_loaded <= rows_loaded + 1'b1;
          if (rows_loaded >= FullRows - RowW'(1)) begin
            state    <= StScan;
            colShift <= 1'b1;
            scan_cnt <= '0;
          end else begin
            state <= StFill;
          end
        end
        StScan: begin
          if (scan_cnt == LastCol) begin
            colShift <= 1'b0;
            scan_cnt <= '0;
            if (load_next) begin
              state    <= StLoad;
              data     <= asm_next;
              rowShift <= 1'b1;
            end else begin
              state <= StFill;
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_rf2d_row_feeder.sv
// Directed bench for rf2d_row_feeder with a behavioural rf2d model and a scan-output scoreboard.
module tb_rf2d_row_feeder;

  localparam int NC = 18;
  localparam int NR = 16;
  localparam int NB = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_start;
  logic [NB-1:0]    pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [NC*NB-1:0] data;
  logic             rowShift;
  logic             colShift;
  logic             rf_reset;
  logic             primed;
  logic             scan_valid;
  logic [4:0]       scan_col;

  rf2d_row_feeder #(.NUM_COL(NC), .NUM_ROW(NR), .NUM_BITS(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .data       (data),
    .rowShift   (rowShift),
    .colShift   (colShift),
    .rf_reset   (rf_reset),
    .primed     (primed),
    .scan_valid (scan_valid),
    .scan_col   (scan_col)
  );

  always #5 clk = ~clk;

  typedef struct {int col; int val;} exp_t;
  exp_t exp_q[$];
  int   model [NR][NC];
  int   checks = 0;
  int   errors = 0;
  int   colshift_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_ready"}, 64'(pix_ready), 0);
    check({tag, "_data"}, 64'(data == '0), 1);
    check({tag, "_rowShift"}, 64'(rowShift), 0);
    check({tag, "_colShift"}, 64'(colShift), 0);
    check({tag, "_rf_reset"}, 64'(rf_reset), 0);
    check({tag, "_primed"}, 64'(primed), 0);
    check({tag, "_scan_valid"}, 64'(scan_valid), 0);
    check({tag, "_scan_col"}, 64'(scan_col), 0);
  endtask

  // rf2d model: outputs are registered, so at the negedge they describe the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      check("exclusive", 64'((rowShift & colShift) | (rf_reset & (rowShift | colShift))), 0);
      if (colShift) colshift_total++;
      if (scan_valid) begin
        check("scan_pending", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("scan_col", 64'(scan_col), 64'(e.col));
          check("scan_res", 64'(model[0][0]), 64'(e.val));
        end
      end
      if (rf_reset) begin
        for (int i = 0; i < NR; i++) for (int j = 0; j < NC; j++) model[i][j] = 0;
      end else if (rowShift) begin
        for (int i = 0; i < NR - 1; i++) model[i] = model[i+1];
        for (int j = 0; j < NC; j++) model[NR-1][j] = int'(data[j*NB +: NB]);
      end else if (colShift) begin
        for (int i = 0; i < NR; i++) begin
          int t;
          t = model[i][0];
          for (int j = 0; j < NC - 1; j++) model[i][j] = model[i][j+1];
          model[i][NC-1] = t;
        end
      end
    end
  end

  task automatic send_pix(input int v, output int stalls);
    stalls = 0;
    @(negedge clk);
    pix_in    = v[NB-1:0];
    pix_valid = 1'b1;
    #1;
    while (!pix_ready && stalls < 100) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    check("pix_accept", 64'(pix_ready), 1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  // Row r carries base+32*r+c; once it is the 16th or later row of the frame, its load
  // triggers a scan of row r-15.
  task automatic send_row(input int base, input int r, input bit toggle, output int stalls);
    int s;
    stalls = 0;
    for (int c = 0; c < NC; c++) begin
      send_pix(base + 32 * r + c, s);
      stalls += s;
      if (toggle && c != NC - 1) @(negedge clk);
    end
    if (r >= NR - 1)
      for (int c = 0; c < NC; c++) exp_q.push_back('{col: c, val: base + 32 * (r - NR + 1) + c});
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || scan_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 0);
  endtask

  task automatic pulse_fs(input string tag);
    @(negedge clk);
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_in      = 10'd999;
    #1;
    check({tag, "_ready"}, 64'(pix_ready), 0);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    check({tag, "_rf_reset"}, 64'(rf_reset), 1);
    check({tag, "_primed"}, 64'(primed), 0);
    check({tag, "_colShift"}, 64'(colShift), 0);
    exp_q.delete();
  endtask

  initial begin
    int st;
    int n;
    reset       = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_in      = '0;
    #3;
    check_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // First row 1..18, no priming.
    send_row(1, 0, 1'b0, st);
    check("t1_rowShift", 64'(rowShift), 1);
    check("t1_data_lo", 64'(data[9:0]), 1);
    check("t1_data_hi", 64'(data[179:170]), 18);
    check("t1_primed", 64'(primed), 0);
    @(negedge clk);
    @(negedge clk);
    check("t1_no_colShift", 64'(colshift_total), 0);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    colshift_total = 0;

    // Sixteen rows prime the array; row 16 is streamed during the first scan.
    for (int r = 0; r < NR; r++) send_row(0, r, 1'b0, st);
    check("t2_rowShift", 64'(rowShift), 1);
    send_row(0, 16, 1'b0, st);
    check("t3_stalls", 64'(st), 1);
    check("t3_rowShift", 64'(rowShift), 1);
    check("t3_colShift", 64'(colShift), 0);
    check("t3_scan_len", 64'(colshift_total), 18);
    check("t3_primed", 64'(primed), 1);
    check("t3_data_lo", 64'(data[9:0]), 512);
    check("t3_data_hi", 64'(data[179:170]), 529);

    // Gappy row, then a row whose first pixel must wait out the LOAD cycle.
    send_row(0, 17, 1'b1, st);
    check("t4_stalls", 64'(st), 1);
    check("t4_rowShift", 64'(rowShift), 1);
    check("t4_data_lo", 64'(data[9:0]), 544);
    check("t4_data_hi", 64'(data[179:170]), 561);
    send_row(0, 18, 1'b0, st);
    check("t4_wait", 64'(st), 1);
    wait_drain("t4_drain");
    check("t4_scan_total", 64'(colshift_total), 72);

    // Frame restart with a partial row in flight.
    pulse_fs("t5a");
    for (int r = 0; r < 3; r++) send_row(512, r, 1'b0, st);
    for (int c = 0; c < 7; c++) send_pix(512 + 96 + c, st);
    pulse_fs("t5b");
    send_row(256, 0, 1'b0, st);
    check("t5_data_lo", 64'(data[9:0]), 256);
    check("t5_data_hi", 64'(data[179:170]), 273);
    check("t5_primed", 64'(primed), 0);
    for (int r = 1; r < NR; r++) send_row(256, r, 1'b0, st);

    // Asynchronous reset in the middle of a scan.
    n = 0;
    while (!(scan_valid && scan_col == 5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_col5", 64'(scan_valid && scan_col == 5), 1);
    #1;
    reset = 1'b0;
    #1;
    check_zero("t6_async");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_zero("t6_hold");
    reset = 1'b1;
    for (int r = 0; r < NR; r++) send_row(0, r, 1'b0, st);
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
